// File: rtl/clock_pkg.sv
// Shared types and display helpers for the clock_core_set time-of-day core.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } set_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Active-high gfedcba pattern for one decimal digit; out-of-range codes go dark.
    function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b011_1111;
            4'd1:    pat = 7'b000_0110;
            4'd2:    pat = 7'b101_1011;
            4'd3:    pat = 7'b100_1111;
            4'd4:    pat = 7'b110_0110;
            4'd5:    pat = 7'b110_1101;
            4'd6:    pat = 7'b111_1101;
            4'd7:    pat = 7'b000_0111;
            4'd8:    pat = 7'b111_1111;
            4'd9:    pat = 7'b110_1111;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Hour as displayed, returned as {tens, ones}; 12-hour shows 0 as 12 and 13-23 as 1-11.
    function automatic logic [7:0] hour_digits(input logic [4:0] hour, input logic mode_12h);
        logic [4:0] disp;
        logic [3:0] tens;
        logic [3:0] ones;
        disp = hour;
        if (mode_12h) begin
            if (hour == 5'd0) begin
                disp = 5'd12;
            end else if (hour > 5'd12) begin
                disp = hour - 5'd12;
            end
        end
        if (disp >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(disp - 5'd20);
        end else if (disp >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(disp - 5'd10);
        end else begin
            tens = 4'd0;
            ones = 4'(disp);
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/clock_core_set_if.sv
// Button/display bundle between the clock core and the board side.
interface clock_core_set_if;
    logic       mode_12h;
    logic       btn_mode;
    logic       btn_inc;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] seg3;
    logic [6:0] seg4;
    logic [6:0] seg5;
    logic [6:0] seg6;
    logic       pm;
    logic       sec_tick;
    logic [1:0] set_state;

    modport master (
        output mode_12h, btn_mode, btn_inc,
        input  seg1, seg2, seg3, seg4, seg5, seg6, pm, sec_tick, set_state
    );

    modport slave (
        input  mode_12h, btn_mode, btn_inc,
        output seg1, seg2, seg3, seg4, seg5, seg6, pm, sec_tick, set_state
    );
endinterface

// File: rtl/clock_seg_dec.sv
// One 7-segment digit: value plus blank flag to segment lines of the chosen polarity.
module clock_seg_dec
    import clock_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);
    logic [6:0] lit;

    assign lit = blank ? SEG_BLANK : seg_pattern(value);
    assign seg = SEG_ACTIVE_LOW ? ~lit : lit;
endmodule

// File: rtl/clock_core_set.sv
// HH:MM:SS time-of-day core with prescaler, button time-set FSM, blink and 12/24-hour display.
module clock_core_set
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 50000000,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    clock_core_set_if.slave bus
);
    localparam int unsigned TICK_W  = $clog2(TICK_DIV);
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    set_state_e         state_q, state_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               mode_prev_q, mode_prev_d;
    logic               inc_prev_q, inc_prev_d;
    logic               sec_tick_q, sec_tick_d;
    logic [3:0]         s_ones_q, s_ones_d;
    logic [3:0]         s_tens_q, s_tens_d;
    logic [3:0]         m_ones_q, m_ones_d;
    logic [3:0]         m_tens_q, m_tens_d;
    logic [4:0]         hour_q, hour_d;

    logic mode_edge;
    logic inc_edge;

    assign mode_edge = bus.btn_mode & ~mode_prev_q;
    // A mode edge swallows an increment arriving in the same cycle.
    assign inc_edge  = bus.btn_inc & ~inc_prev_q & ~mode_edge;

    always_comb begin
        // NOTE: every _d starts from its _q (or a fixed default) so no path can infer a latch.
        state_d     = state_q;
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        sec_tick_d  = 1'b0;
        s_ones_d    = s_ones_q;
        s_tens_d    = s_tens_q;
        m_ones_d    = m_ones_q;
        m_tens_d    = m_tens_q;
        hour_d      = hour_q;
        mode_prev_d = bus.btn_mode;
        inc_prev_d  = bus.btn_inc;

        case (state_q)
            ST_RUN: begin
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
                if (mode_edge) begin
                    state_d  = ST_SET_HR;
                    presc_d  = '0;
                    s_ones_d = '0;
                    s_tens_d = '0;
                end else if (presc_q == TICK_LAST) begin
                    presc_d    = '0;
                    sec_tick_d = 1'b1;
                    if (s_ones_q != 4'd9) begin
                        s_ones_d = s_ones_q + 4'd1;
                    end else begin
                        s_ones_d = '0;
                        if (s_tens_q != 4'd5) begin
                            s_tens_d = s_tens_q + 4'd1;
                        end else begin
                            s_tens_d = '0;
                            if (m_ones_q != 4'd9) begin
                                m_ones_d = m_ones_q + 4'd1;
                            end else begin
                                m_ones_d = '0;
                                if (m_tens_q != 4'd5) begin
                                    m_tens_d = m_tens_q + 4'd1;
                                end else begin
                                    m_tens_d = '0;
                                    hour_d   = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                                end
                            end
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            ST_SET_HR, ST_SET_MIN: begin
                presc_d = '0;
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_on_d  = ~blink_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end

                if (mode_edge) begin
                    state_d     = (state_q == ST_SET_HR) ? ST_SET_MIN : ST_RUN;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end else if (inc_edge) begin
                    if (state_q == ST_SET_HR) begin
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else if (m_ones_q != 4'd9) begin
                        m_ones_d = m_ones_q + 4'd1;
                    end else begin
                        // Minute wrap stays inside the minute field while setting.
                        m_ones_d = '0;
                        m_tens_d = (m_tens_q == 4'd5) ? 4'd0 : m_tens_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            sec_tick_q  <= 1'b0;
            s_ones_q    <= '0;
            s_tens_q    <= '0;
            m_ones_q    <= '0;
            m_tens_q    <= '0;
            hour_q      <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
            sec_tick_q  <= sec_tick_d;
            s_ones_q    <= s_ones_d;
            s_tens_q    <= s_tens_d;
            m_ones_q    <= m_ones_d;
            m_tens_q    <= m_tens_d;
            hour_q      <= hour_d;
        end
    end

    logic [7:0] hr_digits;
    logic       blank_hr;
    logic       blank_min;
    logic [3:0] digit_val   [6];
    logic       digit_blank [6];
    logic [6:0] digit_seg   [6];

    assign hr_digits = hour_digits(hour_q, bus.mode_12h);
    assign blank_hr  = (state_q == ST_SET_HR)  && !blink_on_q;
    assign blank_min = (state_q == ST_SET_MIN) && !blink_on_q;

    always_comb begin
        digit_val[0]   = s_ones_q;
        digit_val[1]   = s_tens_q;
        digit_val[2]   = m_ones_q;
        digit_val[3]   = m_tens_q;
        digit_val[4]   = hr_digits[3:0];
        digit_val[5]   = hr_digits[7:4];
        digit_blank[0] = 1'b0;
        digit_blank[1] = 1'b0;
        digit_blank[2] = blank_min;
        digit_blank[3] = blank_min;
        digit_blank[4] = blank_hr;
        // 12-hour display suppresses a leading hour-tens zero.
        digit_blank[5] = blank_hr || (bus.mode_12h && (hr_digits[7:4] == 4'd0));
    end

    for (genvar i = 0; i < 6; i++) begin : g_dec
        clock_seg_dec #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_dec (
            .value(digit_val[i]),
            .blank(digit_blank[i]),
            .seg  (digit_seg[i])
        );
    end

    assign bus.seg1      = digit_seg[0];
    assign bus.seg2      = digit_seg[1];
    assign bus.seg3      = digit_seg[2];
    assign bus.seg4      = digit_seg[3];
    assign bus.seg5      = digit_seg[4];
    assign bus.seg6      = digit_seg[5];
    assign bus.pm        = bus.mode_12h && (hour_q >= 5'd12);
    assign bus.sec_tick  = sec_tick_q;
    assign bus.set_state = state_q;
endmodule

// File: tb/tb_clock_core_set.sv
// Self-checking bench for clock_core_set with a small time model and an expected-display queue.
module tb_clock_core_set;
    localparam int TICK  = 4;
    localparam int BLINK = 3;

    logic clk;
    logic rst;
    clock_core_set_if bus ();

    clock_core_set #(
        .TICK_DIV      (TICK),
        .BLINK_DIV     (BLINK),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int tick_in_set = 0;

    always @(negedge clk) begin
        if (!rst && bus.set_state != 2'd0 && bus.sec_tick) tick_in_set++;
    end

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    typedef struct {
        string name;
        int    h;
        int    m;
        int    s;
        int    st;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit         m12;
        int         hour;
        logic [6:0] s6;
        logic [6:0] s5;
        bit         pm;
    } hr_vec_t;
    hr_vec_t hr_tab [9];

    int m_h = 0;
    int m_m = 0;
    int m_s = 0;
    int m_st = 0;
    int entry_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [41:0] disp_of(int h, int m, int s, bit m12, bit bh, bit bm);
        int dh;
        logic [6:0] d6, d5, d4, d3;
        dh = h;
        if (m12) begin
            dh = h % 12;
            if (dh == 0) dh = 12;
        end
        d6 = (m12 && dh < 10) ? 7'h00 : seg_tab[dh / 10];
        d5 = seg_tab[dh % 10];
        if (bh) begin
            d6 = 7'h00;
            d5 = 7'h00;
        end
        d4 = bm ? 7'h00 : seg_tab[m / 10];
        d3 = bm ? 7'h00 : seg_tab[m % 10];
        return {d6, d5, d4, d3, seg_tab[s / 10], seg_tab[s % 10]};
    endfunction

    task automatic adv_sec();
        int t;
        t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = t / 3600;
        m_m = (t / 60) % 60;
        m_s = t % 60;
    endtask

    task automatic sb_push(input string name);
        exp_t e;
        e.name = name;
        e.h = m_h;
        e.m = m_m;
        e.s = m_s;
        e.st = m_st;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        bit blink_on;
        logic [41:0] want;
        logic [41:0] got;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got nothing expected a queued record");
            return;
        end
        e = sb_q.pop_front();
        blink_on = (((cyc - entry_cyc) / BLINK) % 2) == 0;
        want = disp_of(e.h, e.m, e.s, bus.mode_12h, (e.st == 1) && !blink_on, (e.st == 2) && !blink_on);
        got = {bus.seg6, bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1};
        check({e.name, "_segs"}, got, want);
        check({e.name, "_pm"}, bus.pm, (bus.mode_12h && e.h >= 12));
        check({e.name, "_state"}, bus.set_state, e.st);
    endtask

    task automatic press_inc();
        if (m_st == 1) m_h = (m_h + 1) % 24;
        else if (m_st == 2) m_m = (m_m + 1) % 60;
        sb_push("inc");
        bus.btn_inc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb_check();
        bus.btn_inc = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_mode();
        if (m_st == 0) begin
            m_st = 1;
            m_s = 0;
        end else if (m_st == 1) begin
            m_st = 2;
        end else begin
            m_st = 0;
        end
        sb_push("mode");
        bus.btn_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        entry_cyc = cyc;
        sb_check();
        bus.btn_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ticks(input string name, input int n);
        int got;
        got = 0;
        for (int c = 0; c < (n + 2) * TICK && got < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.sec_tick) begin
                got++;
                adv_sec();
            end
        end
        check({name, "_ticks"}, got, n);
        sb_push(name);
        sb_check();
    endtask

    // Edges counted from the edge that sampled the triggering event until sec_tick shows.
    task automatic measure_tick(input string name, input int start);
        int n;
        bit seen;
        n = start;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            seen = bus.sec_tick;
        end
        check(name, n, TICK + 1);
        if (seen) adv_sec();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected one within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ticks;
        int last;
        int gaps_bad;
        int hr_blank;
        int min_blank;

        hr_tab[0] = '{1'b1, 0,  7'b0000110, 7'b1011011, 1'b0};
        hr_tab[1] = '{1'b1, 9,  7'b0000000, 7'b1101111, 1'b0};
        hr_tab[2] = '{1'b1, 12, 7'b0000110, 7'b1011011, 1'b1};
        hr_tab[3] = '{1'b1, 13, 7'b0000000, 7'b0000110, 1'b1};
        hr_tab[4] = '{1'b0, 13, 7'b0000110, 7'b1001111, 1'b0};
        hr_tab[5] = '{1'b1, 22, 7'b0000110, 7'b0111111, 1'b1};
        hr_tab[6] = '{1'b1, 23, 7'b0000110, 7'b0000110, 1'b1};
        hr_tab[7] = '{1'b0, 23, 7'b1011011, 7'b1001111, 1'b0};
        hr_tab[8] = '{1'b0, 0,  7'b0111111, 7'b0111111, 1'b0};

        rst = 1'b1;
        bus.mode_12h = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_push("reset");
        sb_check();
        check("reset_sec_tick", bus.sec_tick, 1'b0);

        // One minute of running time.
        ticks = 0;
        last = 0;
        gaps_bad = 0;
        for (int i = 1; i <= 60 * TICK; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.sec_tick) begin
                ticks++;
                if (i - last != TICK) gaps_bad++;
                last = i;
                adv_sec();
            end
        end
        check("run_tick_count", ticks, 60);
        check("run_tick_spacing", gaps_bad, 0);
        check("run_seg1", bus.seg1, 7'b0111111);
        check("run_seg2", bus.seg2, 7'b0111111);
        sb_push("one_minute");
        sb_check();

        // Set 23:59 and roll over midnight.
        press_mode();
        while (m_h != 23) press_inc();
        press_mode();
        while (m_m != 59) press_inc();
        m_st = 0;
        sb_push("back_to_run");
        bus.btn_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.btn_mode = 1'b0;
        sb_check();
        measure_tick("tick_after_set", 1);
        wait_ticks("pre_wrap", 58);
        wait_ticks("midnight", 1);

        // Hour edit: seconds clear, 24 increments wrap, field blinks.
        wait_ticks("run3", 3);
        press_mode();
        for (int i = 0; i < 24; i++) press_inc();
        hr_blank = 0;
        min_blank = 0;
        for (int i = 0; i < 4 * BLINK; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.seg6 == 7'h00 && bus.seg5 == 7'h00) hr_blank++;
            if (bus.seg3 == 7'h00) min_blank++;
        end
        check("blink_hr_blank_cycles", hr_blank, 2 * BLINK);
        check("blink_min_blank_cycles", min_blank, 0);

        // 12/24-hour mapping, read in SET_MIN where the hour digits are steady.
        for (int i = 0; i < 9; i++) begin
            while (m_h != hr_tab[i].hour) press_inc();
            press_mode();
            bus.mode_12h = hr_tab[i].m12;
            #1;
            check($sformatf("hr%0d_seg6", i), bus.seg6, hr_tab[i].s6);
            check($sformatf("hr%0d_seg5", i), bus.seg5, hr_tab[i].s5);
            check($sformatf("hr%0d_pm", i), bus.pm, hr_tab[i].pm);
            press_mode();
            press_mode();
        end

        // Mode and inc edges together in SET_HR: mode wins.
        m_st = 2;
        sb_push("mode_and_inc");
        bus.btn_mode = 1'b1;
        bus.btn_inc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        entry_cyc = cyc;
        sb_check();
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Minute wrap without hour carry, then stop at 42.
        for (int i = 0; i < 102; i++) press_inc();

        // Reset in the middle of SET_MIN.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_h = 0;
        m_m = 0;
        m_s = 0;
        m_st = 0;
        sb_push("mid_set_reset");
        sb_check();
        measure_tick("tick_after_rst", 1);

        // Increment is ignored while running.
        press_inc();

        check("no_tick_in_set", tick_in_set, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
